// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//   - stall-vector bit indices and the three legal stall patterns
//   - FSM state encoding
//   - reset-level / zero-word constants used across the core
package pipe_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam int STALL_W   = 6;
    localparam int ST_PC     = 0;
    localparam int ST_IF_ID  = 1;
    localparam int ST_ID_EX  = 2;
    localparam int ST_EX_MEM = 3;
    localparam int ST_MEM_WB = 4;
    localparam int ST_WB     = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        FLUSH   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and pipe_ctrl.
//   requests : stallreq_id, stallreq_ex, ex_mc_start, ex_mc_len, flush_req, flush_pc
//   controls : stall[5:0], flush, new_pc, mc_busy, mc_done, stall_cycles
// master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int MC_LEN_W = 6,
    parameter int PERF_W   = 32
);
    logic                stallreq_id;
    logic                stallreq_ex;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                flush_req;
    logic [PC_W-1:0]     flush_pc;

    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [PC_W-1:0]     new_pc;
    logic                mc_busy;
    logic                mc_done;
    logic [PERF_W-1:0]   stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, ex_mc_start, ex_mc_len, flush_req, flush_pc,
        input  stall, flush, new_pc, mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_mc_start, ex_mc_len, flush_req, flush_pc,
        output stall, flush, new_pc, mc_busy, mc_done, stall_cycles
    );

endinterface

// File: rtl/pipe_mc_counter.sv
// Loadable down-counter for multi-cycle EX sequencing.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force count to zero (highest priority after reset)
//   load      : load load_val
//   dec       : decrement, stops at zero
//   cnt, zero : current count and zero flag
module pipe_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable)      cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges ID/EX stall requests, sequences multi-cycle
// EX ops, and issues a one-cycle-per-request flush with redirect PC.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (requests in, stall/flush/new_pc/mc_busy/
//              mc_done/stall_cycles out)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int MC_LEN_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    pc_state_e           state, state_nxt;
    logic [MC_LEN_W-1:0] cnt;
    logic                cnt_zero;
    logic                mc_go;
    logic                ex_stall;
    logic [STALL_W-1:0]  stall;
    logic                mc_busy, mc_done, flush;
    logic [PC_W-1:0]     new_pc;
    logic [PERF_W-1:0]   stall_cycles;

    // A length of 0 or 1 is a single-cycle op and never enters MC_BUSY.
    assign mc_go = bus.ex_mc_start && (bus.ex_mc_len >= MC_LEN_W'(2));

    // Count holds the MC_BUSY cycles still to go before the done cycle;
    // the start cycle and the done cycle are not counted.
    pipe_mc_counter #(.W(MC_LEN_W)) u_mc_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.flush_req),
        .load     (state == IDLE && mc_go),
        .load_val (bus.ex_mc_len - MC_LEN_W'(2)),
        .dec      (state == MC_BUSY),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) state <= IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush_req) begin
            state_nxt = FLUSH;
        end else begin
            unique case (state)
                IDLE:    if (mc_go)    state_nxt = MC_BUSY;
                MC_BUSY: if (cnt_zero) state_nxt = IDLE;
                FLUSH:                 state_nxt = IDLE;
                default:               state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mc_busy  = (state == MC_BUSY);
        mc_done  = (state == MC_BUSY) && cnt_zero;
        flush    = (state == FLUSH);
        ex_stall = bus.stallreq_ex
                 | ((state == IDLE) & mc_go)
                 | ((state == MC_BUSY) & ~cnt_zero);
        if (state == FLUSH)       stall = STALL_NONE;
        else if (ex_stall)        stall = STALL_EX;
        else if (bus.stallreq_id) stall = STALL_ID;
        else                      stall = STALL_NONE;
    end

    // Redirect target is recaptured on every flush request so back-to-back
    // requests always present the latest handler address.
    always_ff @(posedge clk) begin
        if (rst == RstEnable)  new_pc <= PC_W'(ZeroWord);
        else if (bus.flush_req) new_pc <= bus.flush_pc;
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            stall_cycles <= '0;
        else if (stall != STALL_NONE && stall_cycles != '1)
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

    assign bus.stall        = stall;
    assign bus.flush        = flush;
    assign bus.new_pc       = new_pc;
    assign bus.mc_busy      = mc_busy;
    assign bus.mc_done      = mc_done;
    assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl. Stimulus computes each cycle's expected
// outputs from a cycle-occupancy model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_pipe_ctrl;

    localparam int PC_W     = 32;
    localparam int MC_LEN_W = 6;
    localparam int PERF_W   = 8;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    typedef struct {
        logic [5:0]        stall;
        logic              flush;
        logic [PC_W-1:0]   pc;
        logic              busy;
        logic              done;
        logic [PERF_W-1:0] perf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.PC_W(PC_W), .MC_LEN_W(MC_LEN_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.PC_W(PC_W), .MC_LEN_W(MC_LEN_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: whether this cycle is a flush cycle, how many cycles the
    // current multi-cycle op still occupies EX, last redirect PC, perf count.
    bit              m_flush = 0;
    int              m_left  = 0;
    logic [PC_W-1:0] m_pc    = '0;
    int              m_perf  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit id, input bit ex, input bit st,
                        input int len, input bit fr, input logic [PC_W-1:0] pc);
        exp_t e;
        bit   in_op, started, exs;
        @(posedge clk);
        #1;
        rst             = r;
        bus.stallreq_id = id;
        bus.stallreq_ex = ex;
        bus.ex_mc_start = st;
        bus.ex_mc_len   = MC_LEN_W'(len);
        bus.flush_req   = fr;
        bus.flush_pc    = pc;
        if (r) begin
            m_flush = 0; m_left = 0; m_pc = '0; m_perf = 0;
            return;
        end
        in_op   = (m_left > 0);
        started = !m_flush && !in_op && st && (len >= 2);
        exs     = ex || started || (in_op && m_left > 1);
        if (m_flush)  e.stall = 6'b000000;
        else if (exs) e.stall = 6'b001111;
        else if (id)  e.stall = 6'b000111;
        else          e.stall = 6'b000000;
        e.flush = m_flush;
        e.pc    = m_pc;
        e.busy  = in_op;
        e.done  = in_op && (m_left == 1);
        e.perf  = PERF_W'(m_perf);
        q.push_back(e);
        if (e.stall != 0 && m_perf < PERF_MAX) m_perf++;
        if (fr) begin
            m_flush = 1; m_left = 0; m_pc = pc;
        end else begin
            m_flush = 0;
            if (started)    m_left = len - 1;
            else if (in_op) m_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Monitor: the DUT presents a full control word every cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",        32'(bus.stall),        32'(e.stall));
                chk("flush",        32'(bus.flush),        32'(e.flush));
                chk("new_pc",       32'(bus.new_pc),       32'(e.pc));
                chk("mc_busy",      32'(bus.mc_busy),      32'(e.busy));
                chk("mc_done",      32'(bus.mc_done),      32'(e.done));
                chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.perf));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.ex_mc_start = 0;
        bus.ex_mc_len = '0; bus.flush_req = 0; bus.flush_pc = '0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, '0);
        idle(10);
        // ID stall pulse
        step(0, 1, 0, 0, 0, 0, '0);
        idle(3);
        // 4-cycle op
        step(0, 0, 0, 1, 4, 0, '0);
        idle(6);
        // single-cycle lengths
        step(0, 0, 0, 1, 1, 0, '0);
        idle(2);
        step(0, 0, 0, 1, 0, 0, '0);
        idle(2);
        // flush aborts a 10-cycle op
        step(0, 0, 0, 1, 10, 0, '0);
        step(0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
        idle(12);
        // start, ID stall and flush together
        step(0, 1, 0, 1, 5, 1, 32'h8000_0180);
        idle(8);
        // held flush requests
        step(0, 0, 0, 0, 0, 1, 32'h1111_0000);
        step(0, 0, 1, 1, 3, 1, 32'h2222_0000);
        step(0, 1, 0, 0, 0, 1, 32'h3333_0000);
        idle(3);
        // EX external stall during an op, and the longest op
        step(0, 0, 0, 1, 63, 0, '0);
        for (int i = 0; i < 30; i++) step(0, 1, i[0], 1, 2, 0, '0);
        idle(40);
        // reset in the middle of an op
        step(0, 0, 0, 1, 8, 0, '0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, '0);
        idle(8);
        // drive the perf counter into saturation
        for (int i = 0; i < PERF_MAX + 20; i++) step(0, 1, 0, 0, 0, 0, '0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 12)),
                 ($urandom_range(0, 19) == 0),
                 PC_W'($urandom));
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
